// File: rtl/keypad_rx_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_rx_buffer
//  Brief    : Synchronises the scanner press strobe, queues key codes in a
//             small FIFO and raises one fixed-length interrupt per queued key.
//  Revision : 1.0 - initial release
// ============================================================================
module keypad_rx_buffer #(
    parameter int DEPTH    = 4,
    parameter int INTR_LEN = 3,
    parameter int KEY_W    = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    press_in,
    input  logic [KEY_W-1:0]        key_in,
    input  logic                    rd_en,
    input  logic                    clr_ovf,
    output logic [KEY_W-1:0]        key_out,
    output logic                    key_valid,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    interrupt
);

    localparam int                  c_ADDR_W   = $clog2(DEPTH);
    localparam int                  c_CNT_W    = $clog2(INTR_LEN + 1);
    localparam logic [c_ADDR_W:0]   c_FULL     = (c_ADDR_W + 1)'(DEPTH);
    localparam logic [c_CNT_W-1:0]  c_INTR_CNT = c_CNT_W'(INTR_LEN);
    localparam logic [c_CNT_W-1:0]  c_ONE      = c_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PULSE    = 2'd1,
        S_WAIT_ACK = 2'd2
    } state_t;

    logic                 r_s1, r_s2, r_prev, r_live, r_armed;
    logic                 w_push, w_pop, w_wr, w_full, w_ovf_evt;
    logic [KEY_W-1:0]     r_mem [DEPTH];
    logic [c_ADDR_W-1:0]  r_wr_ptr, r_rd_ptr;
    logic [c_ADDR_W:0]    r_count;
    logic                 r_ovf;
    state_t               r_state, w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic                 r_ack, w_ack_nxt;
    logic                 r_intr, w_intr_nxt;

    // Arming waits for a genuine low sample so a press held through reset is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_prev  <= 1'b0;
            r_live  <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_s1    <= press_in;
            r_s2    <= r_s1;
            r_prev  <= r_s2;
            r_live  <= 1'b1;
            r_armed <= r_armed | (r_live & ~r_s1);
        end
    end

    assign w_push    = r_armed & r_s2 & ~r_prev;
    assign w_full    = (r_count == c_FULL);
    assign key_valid = (r_count != '0);
    assign w_pop     = rd_en & key_valid;
    assign w_wr      = w_push & (~w_full | w_pop);
    assign w_ovf_evt = w_push & w_full & ~rd_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr) begin
            r_mem[r_wr_ptr] <= key_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_ovf_evt) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ack   <= 1'b0;
            r_intr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ack   <= w_ack_nxt;
            r_intr  <= w_intr_nxt;
        end
    end

    // An acknowledge seen during the pulse lets the FSM skip WAIT_ACK.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ack_nxt   = r_ack;
        w_intr_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (key_valid) begin
                    w_state_nxt = S_PULSE;
                    w_cnt_nxt   = c_INTR_CNT;
                    w_ack_nxt   = 1'b0;
                    w_intr_nxt  = 1'b1;
                end
            end
            S_PULSE: begin
                w_ack_nxt = r_ack | rd_en;
                if (r_cnt == c_ONE) begin
                    w_state_nxt = (r_ack | rd_en) ? S_IDLE : S_WAIT_ACK;
                end else begin
                    w_cnt_nxt  = r_cnt - 1'b1;
                    w_intr_nxt = 1'b1;
                end
            end
            S_WAIT_ACK: begin
                if (rd_en) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign key_out   = key_valid ? r_mem[r_rd_ptr] : '0;
    assign count     = r_count;
    assign overflow  = r_ovf;
    assign interrupt = r_intr;

endmodule
`default_nettype wire

// File: tb/tb_keypad_rx_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_keypad_rx_buffer
//  Brief    : Scoreboard bench for keypad_rx_buffer with a queue-based model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_rx_buffer;

    localparam int DEPTH    = 4;
    localparam int INTR_LEN = 3;
    localparam int KEY_W    = 4;

    logic             clk      = 1'b0;
    logic             rst_n    = 1'b0;
    logic             press_in = 1'b0;
    logic [KEY_W-1:0] key_in   = '0;
    logic             rd_en    = 1'b0;
    logic             clr_ovf  = 1'b0;
    logic [KEY_W-1:0] key_out;
    logic             key_valid;
    logic [2:0]       count;
    logic             overflow;
    logic             interrupt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    keypad_rx_buffer #(.DEPTH(DEPTH), .INTR_LEN(INTR_LEN), .KEY_W(KEY_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .press_in  (press_in),
        .key_in    (key_in),
        .rd_en     (rd_en),
        .clr_ovf   (clr_ovf),
        .key_out   (key_out),
        .key_valid (key_valid),
        .count     (count),
        .overflow  (overflow),
        .interrupt (interrupt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of keys plus pulse bookkeeping, advanced at each
    // negedge using the inputs the next rising edge will see.
    logic [KEY_W-1:0] m_q[$];
    logic [KEY_W-1:0] sb_q[$];
    logic [KEY_W-1:0] mon_exp;
    bit m_ovf, m_seen_low, m_last, m_acked, m_wait;
    bit m_push, m_rise, m_ovf_evt;
    int m_due, m_left, m_sz0;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_q.delete();
            sb_q.delete();
            m_ovf = 0; m_seen_low = 0; m_last = press_in;
            m_due = 0; m_left = 0; m_wait = 0; m_acked = 0;
        end
        chk("count", 32'(count), 32'(m_q.size()));
        chk("key_valid", 32'(key_valid), 32'(m_q.size() != 0));
        chk("key_out", 32'(key_out), (m_q.size() != 0) ? 32'(m_q[0]) : 32'd0);
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("interrupt", 32'(interrupt), 32'(m_left > 0));
        if (rst_n) begin
            m_rise = press_in && !m_last && m_seen_low;
            if (!press_in) m_seen_low = 1;
            m_last = press_in;
            m_push = 0;
            if (m_rise) m_due = 3;
            if (m_due > 0) begin
                m_due--;
                if (m_due == 0) m_push = 1;
            end
            m_sz0 = m_q.size();
            if (m_left > 0) begin
                if (rd_en) m_acked = 1;
                m_left--;
                if (m_left == 0) m_wait = !m_acked;
            end else if (m_wait) begin
                if (rd_en) m_wait = 0;
            end else if (m_sz0 > 0) begin
                m_left  = INTR_LEN;
                m_acked = 0;
            end
            m_ovf_evt = 0;
            if (rd_en && m_q.size() > 0) void'(m_q.pop_front());
            if (m_push) begin
                if (m_q.size() < DEPTH) begin
                    m_q.push_back(key_in);
                    sb_q.push_back(key_in);
                end else begin
                    m_ovf_evt = 1;
                end
            end
            if (m_ovf_evt) m_ovf = 1;
            else if (clr_ovf) m_ovf = 0;
        end
    end

    // Monitor: every accepted read must return the oldest key still queued.
    always @(negedge clk) begin
        if (rst_n && rd_en && key_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL read_key: got %0h expected none queued at %0t", key_out, $time);
            end else begin
                mon_exp = sb_q.pop_front();
                chk("read_key", 32'(key_out), 32'(mon_exp));
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic press(input logic [KEY_W-1:0] k, input int hi, input int lo, input bit rnd);
        key_in   = k;
        press_in = 1'b1;
        for (int i = 0; i < hi; i++) begin
            if (rnd) begin
                rd_en   = ($urandom % 4 == 0);
                clr_ovf = ($urandom % 8 == 0);
            end
            tick();
        end
        press_in = 1'b0;
        for (int i = 0; i < lo; i++) begin
            if (rnd) begin
                rd_en   = ($urandom % 4 == 0);
                clr_ovf = ($urandom % 8 == 0);
            end
            tick();
        end
        rd_en   = 1'b0;
        clr_ovf = 1'b0;
    endtask

    task automatic wait_int(input logic level, input int budget, input string name);
        bit ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            if (interrupt === level) ok = 1;
            else tick();
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: interrupt never reached %0b within %0d cycles", name, level, budget);
        end
    endtask

    task automatic ack_read();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic drain_acked(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            wait_int(1'b0, 10, {name, "_fall"});
            ack_read();
            if (i < n - 1) wait_int(1'b1, 10, {name, "_rise"});
        end
    endtask

    initial begin
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(3);

        // Single press, one pulse, no repeat without a read
        press(4'h5, 4, 4, 0);
        tick(15);
        chk("t1_count", 32'(count), 32'd1);
        chk("t1_key", 32'(key_out), 32'h5);
        ack_read();
        chk("t1_empty", 32'(count), 32'd0);

        // Long hold queues once
        press(4'h9, 50, 4, 0);
        chk("t2_count", 32'(count), 32'd1);
        ack_read();
        chk("t2_count_rd", 32'(count), 32'd0);
        chk("t2_valid_rd", 32'(key_valid), 32'd0);
        chk("t2_key_rd", 32'(key_out), 32'd0);

        // Fill, overflow, ordered acknowledged reads, clear
        for (int k = 1; k <= 5; k++) press(KEY_W'(k), 3, 3, 0);
        chk("t3_count", 32'(count), 32'd4);
        chk("t3_ovf", 32'(overflow), 32'd1);
        chk("t3_head", 32'(key_out), 32'h1);
        drain_acked(4, "t3");
        tick(2);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("t3_ovf_clr", 32'(overflow), 32'd0);

        // Full FIFO with coincident push and pop, repeated to wrap pointers
        for (int rep = 0; rep < 3; rep++) begin
            for (int k = 0; k < 4; k++) press(KEY_W'(rep * 5 + k + 1), 3, 3, 0);
            key_in   = KEY_W'(rep * 5 + 5);
            press_in = 1'b1;
            tick(2);
            rd_en = 1'b1;
            tick();
            rd_en    = 1'b0;
            press_in = 1'b0;
            tick(3);
            chk("t4_count", 32'(count), 32'd4);
            chk("t4_ovf", 32'(overflow), 32'd0);
            drain_acked(4, "t4");
            tick(4);
        end

        // Press held through reset release is ignored
        rst_n    = 1'b0;
        press_in = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(10);
        chk("t5_held", 32'(count), 32'd0);
        press_in = 1'b0;
        tick(4);
        press(4'hA, 4, 4, 0);
        chk("t5_count", 32'(count), 32'd1);
        ack_read();
        tick(4);

        // Asynchronous reset during the second cycle of a pulse
        press(4'hB, 3, 3, 0);
        press(4'hC, 3, 3, 0);
        press(4'hD, 3, 3, 0);
        ack_read();
        wait_int(1'b1, 10, "t6_rise");
        tick();
        chk("t6_pre_irq", 32'(interrupt), 32'd1);
        chk("t6_pre_count", 32'(count), 32'd2);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_irq", 32'(interrupt), 32'd0);
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_valid", 32'(key_valid), 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(12);
        press(4'h7, 4, 4, 0);
        chk("t6_new", 32'(count), 32'd1);
        ack_read();
        tick(4);

        // Randomised traffic checked by the model and scoreboard
        for (int n = 0; n < 200; n++) begin
            press(KEY_W'($urandom), $urandom_range(6, 3), $urandom_range(6, 3), 1);
        end
        for (int n = 0; n < 40 && count != 0; n++) begin
            ack_read();
            tick(2);
        end
        chk("rand_drained", 32'(count), 32'd0);
        tick(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
